// File: rtl/lamp_fpu_sqrt_round_pkg.sv
// lampFPU_pkg: shared LAMP float widths, result type and round-to-nearest-even helper
package lampFPU_pkg;
  localparam int LAMP_FLOAT_S_DW = 1;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW   = LAMP_FLOAT_S_DW + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F = {8'hFF, 7'h00};
  typedef struct packed {
    logic                       s;
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW-1:0] f;
  } lamp_res_t;
  // Returns {e_out[7:0], f_out[6:0], inexact, ovf}; exponent math is 9 bits to catch overflow
  function automatic logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW+1:0] FUNC_rndNearestEven(
    input logic [LAMP_FLOAT_F_DW+4:0] f,
    input logic [LAMP_FLOAT_E_DW-1:0] e
  );
    logic [LAMP_FLOAT_F_DW+3:0] fn;
    logic [LAMP_FLOAT_E_DW:0]   e9;
    logic [LAMP_FLOAT_E_DW:0]   sum;
    logic                       g;
    logic                       st;
    logic                       up;
    logic                       ovf;
    fn  = f[11] ? {f[11:2], |f[1:0]} : f[10:0];
    e9  = {1'b0, e} + {8'd0, f[11]};
    g   = fn[2];
    st  = |fn[1:0];
    up  = g & (st | fn[3]);
    sum = {1'b0, fn[10:3]} + {8'd0, up};
    e9  = e9 + {8'd0, sum[8]};
    ovf = e9 >= 9'h0FF;
    return ovf ? {INF_E_F, g | st, 1'b1} : {e9[7:0], sum[6:0], g | st, 1'b0};
  endfunction
endpackage

// File: rtl/lamp_fpu_res_fifo.sv
// lamp_fpu_res_fifo: result FIFO with registered head; flags pushes lost to a full buffer
module lamp_fpu_res_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] res_o,
  output logic          drop
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   nxt_rd;
  logic          full;
  logic          pop;
  logic          do_push;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = valid_o & ready_i;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign nxt_rd  = rd_ptr + {{AW{1'b0}}, pop};
  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
  // Pointers and head register; head reflects entries present before this edge's push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_o <= 1'b0;
      res_o   <= '0;
    end else begin
      wr_ptr  <= wr_ptr + {{AW{1'b0}}, do_push};
      rd_ptr  <= nxt_rd;
      valid_o <= wr_ptr != nxt_rd;
      res_o   <= (wr_ptr != nxt_rd) ? mem[nxt_rd[AW-1:0]] : res_o;
    end
  end
endmodule

// File: rtl/lamp_fpu_sqrt_round.sv
// lamp_fpu_sqrt_round: RNE round/pack of sqrt results into a backpressured FIFO; LAMP_SQRT_RND_FLAGS_EN enables inexact/ovf flags
module lamp_fpu_sqrt_round
  import lampFPU_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic [LAMP_FLOAT_S_DW-1:0] s_res_i,
  input  logic [LAMP_FLOAT_E_DW-1:0] e_res_i,
  input  logic [LAMP_FLOAT_F_DW+4:0] f_res_i,
  input  logic                       isToRound_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [LAMP_FLOAT_DW-1:0]   res_o,
  output logic                       drop_o,
  output logic                       inexact_o,
  output logic                       ovf_o,
  input  logic                       clrFlags_i
);
  logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW+1:0] rnd;
  lamp_res_t                                  packed_res;
  logic                                       drop;
  assign rnd        = FUNC_rndNearestEven(f_res_i, e_res_i);
  assign packed_res = isToRound_i ? {s_res_i, rnd[16:2]} : {s_res_i, e_res_i, f_res_i[9:3]};
  lamp_fpu_res_fifo #(.DEPTH(FIFO_DEPTH), .DW(LAMP_FLOAT_DW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (valid_i),
    .din     (packed_res),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .res_o   (res_o),
    .drop    (drop)
  );
  // Sticky drop flag; a clear wins over a same-cycle drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_o <= 1'b0;
    else drop_o <= ~clrFlags_i & (drop_o | drop);
  end
`ifdef LAMP_SQRT_RND_FLAGS_EN
  logic flag_set;
  assign flag_set = valid_i & isToRound_i & ~drop;
  // Sticky rounding flags, set only by results that actually entered the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inexact_o <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      inexact_o <= ~clrFlags_i & (inexact_o | (flag_set & rnd[1]));
      ovf_o     <= ~clrFlags_i & (ovf_o | (flag_set & rnd[0]));
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^rnd[1:0];
  assign inexact_o    = 1'b0;
  assign ovf_o        = 1'b0;
`endif
endmodule

// File: tb/tb_lamp_fpu_sqrt_round.sv
// tb_lamp_fpu_sqrt_round: directed vector table plus backpressure and async reset sequences
module tb_lamp_fpu_sqrt_round;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        s_res_i = 1'b0;
  logic [7:0]  e_res_i = '0;
  logic [11:0] f_res_i = '0;
  logic        isToRound_i = 1'b0;
  logic        ready_i = 1'b1;
  logic        valid_o;
  logic [15:0] res_o;
  logic        drop_o;
  logic        inexact_o;
  logic        ovf_o;
  logic        clrFlags_i = 1'b0;
  int          checks = 0;
  int          errors = 0;
`ifdef LAMP_SQRT_RND_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif
  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [11:0] f;
    logic        rnd;
    logic [15:0] exp_res;
    logic        exp_inx;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs [6];
  lamp_fpu_sqrt_round #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .s_res_i     (s_res_i),
    .e_res_i     (e_res_i),
    .f_res_i     (f_res_i),
    .isToRound_i (isToRound_i),
    .ready_i     (ready_i),
    .valid_o     (valid_o),
    .res_o       (res_o),
    .drop_o      (drop_o),
    .inexact_o   (inexact_o),
    .ovf_o       (ovf_o),
    .clrFlags_i  (clrFlags_i)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic drive(input logic s, input logic [7:0] e, input logic [11:0] f, input logic r);
    valid_i     = 1'b1;
    s_res_i     = s;
    e_res_i     = e;
    f_res_i     = f;
    isToRound_i = r;
  endtask
  initial begin
    vecs[0] = '{"half_even", 1'b0, 8'h80, 12'b01_0000000_100, 1'b1, 16'h4000, 1'b1, 1'b0};
    vecs[1] = '{"half_odd",  1'b0, 8'h80, 12'b01_0000001_100, 1'b1, 16'h4002, 1'b1, 1'b0};
    vecs[2] = '{"carry_out", 1'b0, 8'h80, 12'b01_1111111_110, 1'b1, 16'h4080, 1'b1, 1'b0};
    vecs[3] = '{"norm_ovf",  1'b0, 8'h7F, 12'b10_0000001_000, 1'b1, 16'h4000, 1'b1, 1'b0};
    vecs[4] = '{"saturate",  1'b0, 8'hFE, 12'b01_1111111_111, 1'b1, 16'h7F80, 1'b1, 1'b1};
    vecs[5] = '{"special",   1'b0, 8'hFF, {2'b01, 7'h40, 3'b000}, 1'b0, 16'h7FC0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    check("rst_valid", {15'd0, valid_o}, 16'd0);
    check("rst_res", res_o, 16'h0000);
    check("rst_drop", {15'd0, drop_o}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_inexact", {15'd0, inexact_o}, 16'd0);
    check("rst_ovf", {15'd0, ovf_o}, 16'd0);
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].rnd);
      @(negedge clk);
      valid_i = 1'b0;
      check({vecs[i].name, "_lat_early"}, {15'd0, valid_o}, 16'd0);
      @(negedge clk);
      check({vecs[i].name, "_valid"}, {15'd0, valid_o}, 16'd1);
      check({vecs[i].name, "_res"}, res_o, vecs[i].exp_res);
      check({vecs[i].name, "_inexact"}, {15'd0, inexact_o}, {15'd0, vecs[i].exp_inx & FLAGS});
      check({vecs[i].name, "_ovf"}, {15'd0, ovf_o}, {15'd0, vecs[i].exp_ovf & FLAGS});
      clrFlags_i = 1'b1;
      @(negedge clk);
      clrFlags_i = 1'b0;
      check({vecs[i].name, "_popped"}, {15'd0, valid_o}, 16'd0);
    end
    ready_i = 1'b0;
    drive(1'b1, 8'h11, {2'b01, 7'h22, 3'b000}, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h33, {2'b01, 7'h44, 3'b000}, 1'b0);
    @(negedge clk);
    check("bp_no_drop_yet", {15'd0, drop_o}, 16'd0);
    drive(1'b0, 8'h55, {2'b01, 7'h66, 3'b000}, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    check("bp_head_a", res_o, {1'b1, 8'h11, 7'h22});
    check("bp_drop", {15'd0, drop_o}, 16'd1);
    repeat (2) @(negedge clk);
    check("bp_hold_valid", {15'd0, valid_o}, 16'd1);
    check("bp_hold_a", res_o, {1'b1, 8'h11, 7'h22});
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_pop_b_valid", {15'd0, valid_o}, 16'd1);
    check("bp_pop_b", res_o, {1'b0, 8'h33, 7'h44});
    @(negedge clk);
    check("bp_empty", {15'd0, valid_o}, 16'd0);
    check("bp_drop_sticky", {15'd0, drop_o}, 16'd1);
    clrFlags_i = 1'b1;
    @(negedge clk);
    clrFlags_i = 1'b0;
    check("bp_drop_clr", {15'd0, drop_o}, 16'd0);
    ready_i = 1'b0;
    drive(1'b0, 8'h80, 12'b01_0000001_100, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    check("ar_valid_before", {15'd0, valid_o}, 16'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {15'd0, valid_o}, 16'd0);
    check("ar_res", res_o, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("ar_stays_empty", {15'd0, valid_o}, 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lamp_fpu_sqrt_round.md
# lamp_fpu_sqrt_round

Rounding and packing stage placed directly downstream of the LAMP square-root unit. It takes the sign, exponent and 12-bit extended significand from the sqrt unit (hidden/overflow bits, 7 fraction bits, G/R/S) and normalises it. It rounds to nearest-even and packs the result into a 16-bit LAMP float. Results are buffered in a small FIFO so the consumer can apply backpressure while the upstream unit, which cannot stall, keeps issuing.

## Interface
Parameters:
- FIFO_DEPTH, 2, result buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  one-cycle strobe: the sqrt result fields are valid.
- s_res_i  in  LAMP_FLOAT_S_DW  result sign.
- e_res_i  in  LAMP_FLOAT_E_DW  result exponent, biased.
- f_res_i  in  LAMP_FLOAT_F_DW+5  significand: [11] overflow, [10] hidden, [9:3] fraction, [2:0] G,R,S.
- isToRound_i  in  1  1 = normal result, round it; 0 = special value, pack verbatim.
- ready_i  in  1  consumer accepts res_o this cycle.
- valid_o  out  1  FIFO head is valid.
- res_o  out  16  packed {s, e[7:0], f[6:0]}.
- drop_o  out  1  sticky: a result was lost because the FIFO was full.
- inexact_o  out  1  sticky inexact flag; present only with the flag macro, otherwise tied 0.
- ovf_o  out  1  sticky overflow-to-infinity flag; same condition as inexact_o.
- clrFlags_i  in  1  synchronous clear of drop_o, inexact_o and ovf_o.

## Operation
- Combinational round path, evaluated when valid_i=1 and isToRound_i=1.
- Normalise: if f[11]=1, shift the significand right by 1, OR the bit shifted out into sticky, and set exponent to e+1. Otherwise the significand is used unchanged.
- RNE rule: lsb = f[3], g = f[2], sticky = f[1]|f[0].
  - Round up when g & (sticky | lsb).
  - inexact = g | sticky.
- Rounding carry: if the 8-bit {hidden, frac} wraps from 0xFF, fraction becomes 0 and exponent is incremented.
- Overflow: if the final exponent is at least 0xFF, output is {s, 8'hFF, 7'h00} and ovf is set.
- Exponent arithmetic is done 9 bits wide to detect overflow; the sqrt exponent is never below 1, so there is no underflow path.
- Special values (isToRound_i=0): res = {s_res_i, e_res_i, f_res_i[9:3]}. No rounding, no flags.
- FIFO:
  - Push on valid_i. Pop when valid_o & ready_i.
  - Push while full without a pop: result is dropped, FIFO unchanged, drop_o set.
  - Push and pop in the same cycle while full: both occur, no drop.
  - Pointers are log2(FIFO_DEPTH)+1 bits with natural wrap; full/empty come from the MSB comparison.
- Flags:
  - Set by a pushed result (a dropped result still sets drop_o only).
  - clrFlags_i has priority over a simultaneous set; the event in that cycle is lost.

## Timing
- Reset values: valid_o=0, res_o=16'h0000, drop_o=0, inexact_o=0, ovf_o=0. FIFO is empty, pointers are 0.
- Latency: valid_i at edge N puts the result on res_o with valid_o=1 after edge N+1, when the FIFO was empty. Otherwise it appears behind the older entries.
- res_o is registered from the FIFO head; it holds its value while valid_o=1 and ready_i=0.
- Throughput: one result per cycle while ready_i=1.
- Reset asserted mid-operation: all entries are discarded immediately and valid_o drops asynchronously.
- Flags update on the edge following the triggering push.

## Configuration
- LAMP_SQRT_RND_FLAGS_EN defined: inexact and overflow flag logic is built; inexact_o and ovf_o behave as described above.
- Not defined: the flag registers are removed and inexact_o and ovf_o are constant 0. drop_o and saturation to infinity are always present.

## Structure
- lampFPU_pkg holds the shared definitions:
  - LAMP_FLOAT_S_DW, LAMP_FLOAT_E_DW and LAMP_FLOAT_F_DW.
  - INF_E_F.
  - The function FUNC_rndNearestEven(f, e), returning {e_out, f_out, inexact, ovf}.
  - A typedef for the packed 16-bit result.
- One sub-module, lamp_fpu_res_fifo: a parameterised FIFO with registered head output.

## Test plan
- Exact halfway, even lsb: e=0x80, f=12'b01_0000000_100 -> res_o=16'h4000, inexact_o=1.
- Halfway, odd lsb: e=0x80, f=12'b01_0000001_100 -> res_o=16'h4002.
- Carry-out: e=0x80, f=12'b01_1111111_110 -> res_o=16'h4080. Overflow normalise: e=0x7F, f=12'b10_0000001_000 -> res_o=16'h4000, inexact_o=1.
- Saturation: e=0xFE, f=12'b01_1111111_111 -> res_o=16'h7F80, ovf_o=1. Same stimulus without the macro -> ovf_o=0 and res_o unchanged.
- Special pass-through: isToRound_i=0, s=0, e=0xFF, f[9:3]=7'h40 -> res_o=16'h7FC0, no flags.
- Backpressure: ready_i=0, three consecutive valid_i -> first two held in order, third dropped, drop_o=1. Raise ready_i -> two pops in order. clrFlags_i -> drop_o=0. Async reset mid-stream -> valid_o=0 immediately.
